// File: rtl/remote_comm.sv
// Bench-side remote control for the Knight robot: sends a 16-bit command as two
// back-to-back 8N1 bytes (high byte first) and receives single-byte responses.
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    // ---------------- command sequencer ----------------
    typedef enum logic [1:0] {C_IDLE, C_HIGH, C_LOW} cmd_state_e;

    cmd_state_e cst_q, cst_d;
    logic [7:0] lo_q, lo_d;
    logic       sent_q, sent_d;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cst_q  <= C_IDLE;
            lo_q   <= 8'h00;
            sent_q <= 1'b0;
        end else begin
            cst_q  <= cst_d;
            lo_q   <= lo_d;
            sent_q <= sent_d;
        end
    end

    always_comb begin
        cst_d    = cst_q;
        lo_d     = lo_q;
        sent_d   = sent_q;
        tx_start = 1'b0;
        tx_data  = cmd[15:8];
        case (cst_q)
            C_IDLE: if (send_cmd) begin
                lo_d     = cmd[7:0];
                tx_start = 1'b1;
                sent_d   = 1'b0;
                cst_d    = C_HIGH;
            end
            C_HIGH: if (tx_done) begin
                tx_data  = lo_q;
                tx_start = 1'b1;
                cst_d    = C_LOW;
            end
            C_LOW: if (tx_done) begin
                sent_d = 1'b1;
                cst_d  = C_IDLE;
            end
            default: cst_d = C_IDLE;
        endcase
    end

    assign cmd_sent = sent_q;

    // ---------------- transmitter ----------------
    // Bit index 0 is the start bit, 1..8 data, 9 stop; TX is registered so it
    // changes exactly on bit boundaries.
    logic          tx_busy_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [8:0]    tx_sh_q;
    logic          tx_q;

    assign tx_done = tx_busy_q && (tx_cnt_q == BAUD_LAST) && (tx_bit_q == 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_bit_q  <= 4'd0;
            tx_sh_q   <= '1;
            tx_q      <= 1'b1;
        end else if (tx_start) begin
            tx_busy_q <= 1'b1;
            tx_cnt_q  <= '0;
            tx_bit_q  <= 4'd0;
            tx_sh_q   <= {1'b1, tx_data};
            tx_q      <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BAUD_LAST) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_q      <= 1'b1;
                end else begin
                    tx_bit_q <= tx_bit_q + 4'd1;
                    tx_q     <= tx_sh_q[0];
                    tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    assign TX = tx_q;

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_e;

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e     rst_q, rst_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [2:0]    rbit_q, rbit_d;
    logic [7:0]    rsh_q, rsh_d;
    logic [7:0]    resp_q, resp_d;
    logic          rdy_q, rdy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rst_q     <= R_IDLE;
            rcnt_q    <= '0;
            rbit_q    <= 3'd0;
            rsh_q     <= 8'h00;
            resp_q    <= 8'h00;
            rdy_q     <= 1'b0;
        end else begin
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rst_q     <= rst_d;
            rcnt_q    <= rcnt_d;
            rbit_q    <= rbit_d;
            rsh_q     <= rsh_d;
            resp_q    <= resp_d;
            rdy_q     <= rdy_d;
        end
    end

    always_comb begin
        rst_d  = rst_q;
        rcnt_d = rcnt_q + 1'b1;
        rbit_d = rbit_q;
        rsh_d  = rsh_q;
        resp_d = resp_q;
        rdy_d  = 1'b0;
        case (rst_q)
            R_IDLE: begin
                rcnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rst_d = R_START;
            end
            R_START: if (rcnt_q == HALF_LAST) begin
                // Mid-start-bit recheck rejects short glitches.
                rcnt_d = '0;
                rbit_d = 3'd0;
                rst_d  = rx_s2_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (rcnt_q == BAUD_LAST) begin
                rcnt_d = '0;
                rsh_d  = {rx_s2_q, rsh_q[7:1]};
                rbit_d = rbit_q + 3'd1;
                if (rbit_q == 3'd7) rst_d = R_STOP;
            end
            R_STOP: if (rcnt_q == BAUD_LAST) begin
                // A low stop bit still delivers the byte; just wait for line idle.
                rcnt_d = '0;
                resp_d = rsh_q;
                rdy_d  = 1'b1;
                rst_d  = rx_s2_q ? R_IDLE : R_WAIT;
            end
            R_WAIT: begin
                rcnt_d = '0;
                if (rx_s2_q) rst_d = R_IDLE;
            end
            default: rst_d = R_IDLE;
        endcase
    end

    assign resp     = resp_q;
    assign resp_rdy = rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm: TX framing/timing, RX bytes, ignored strobes,
// glitch rejection, concurrent RX/TX and mid-frame reset.
module tb_remote_comm;

    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd = 16'h0000;
    logic        send_cmd = 1'b0;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    int n_chk = 0;
    int n_err = 0;
    int rdy_cnt = 0;

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .send_cmd(send_cmd),
        .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst && resp_rdy) rdy_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Leaves the caller 1ns after the accepting edge.
    task automatic send(input logic [15:0] c);
        @(negedge clk);
        cmd = c;
        send_cmd = 1'b1;
        @(posedge clk);
        #1 send_cmd = 1'b0;
    endtask

    // Samples TX mid-bit for both frames, then pins the cmd_sent rising edge.
    task automatic tx_cmd(input logic [15:0] exp, input string tag);
        logic [9:0] fr;
        repeat (B/2) @(posedge clk);
        #1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 10; k++) begin
                if (f != 0 || k != 0) begin
                    repeat (B) @(posedge clk);
                    #1;
                end
                fr[k] = TX;
            end
            chk({tag, f ? "_lo_start" : "_hi_start"}, 32'(fr[0]), 32'd0);
            chk({tag, f ? "_lo_data" : "_hi_data"}, 32'(fr[8:1]), f ? 32'(exp[7:0]) : 32'(exp[15:8]));
            chk({tag, f ? "_lo_stop" : "_hi_stop"}, 32'(fr[9]), 32'd1);
        end
        repeat (B/2 - 1) @(posedge clk);
        #1 chk({tag, "_sent_early"}, 32'(cmd_sent), 32'd0);
        @(posedge clk);
        #1 chk({tag, "_sent"}, 32'(cmd_sent), 32'd1);
    endtask

    task automatic drive_rx(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            RX = f[k];
            repeat (B) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int c0;
        int lows;

        // 1. reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_sent", 32'(cmd_sent), 32'd0);
        chk("rst_rdy", 32'(resp_rdy), 32'd0);
        chk("rst_resp", 32'(resp), 32'h00);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);

        // 2. basic command
        send(16'h4002);
        chk("c1_busy_tx", 32'(TX), 32'd0);
        tx_cmd(16'h4002, "c1");

        // 3. two response bytes
        c0 = rdy_cnt;
        drive_rx(8'hA5);
        repeat (4) @(posedge clk);
        #1 chk("rx1_pulses", 32'(rdy_cnt - c0), 32'd1);
        chk("rx1_resp", 32'(resp), 32'hA5);
        c0 = rdy_cnt;
        drive_rx(8'h5A);
        repeat (4) @(posedge clk);
        #1 chk("rx2_pulses", 32'(rdy_cnt - c0), 32'd1);
        chk("rx2_resp", 32'(resp), 32'h5A);

        // 4. strobe during a frame is ignored
        send(16'h4BF1);
        fork
            tx_cmd(16'h4BF1, "c2");
            begin
                repeat (5*B) @(posedge clk);
                #2 cmd = 16'h1234;
                send_cmd = 1'b1;
                @(posedge clk);
                #2 send_cmd = 1'b0;
            end
        join
        lows = 0;
        repeat (2*B) begin
            @(posedge clk);
            #1 if (!TX) lows++;
        end
        chk("c2_no_extra", 32'(lows), 32'd0);
        chk("c2_sent_hold", 32'(cmd_sent), 32'd1);
        send(16'h1234);
        chk("c3_sent_clr", 32'(cmd_sent), 32'd0);
        tx_cmd(16'h1234, "c3");

        // 5. glitch rejection, then RX while TX busy
        c0 = rdy_cnt;
        @(posedge clk);
        #1 RX = 1'b0;
        repeat (B/4) @(posedge clk);
        #1 RX = 1'b1;
        repeat (2*B) @(posedge clk);
        #1 chk("glitch_pulses", 32'(rdy_cnt - c0), 32'd0);
        chk("glitch_resp", 32'(resp), 32'h5A);
        c0 = rdy_cnt;
        fork
            begin
                send(16'h55AA);
                tx_cmd(16'h55AA, "c4");
            end
            begin
                repeat (3*B) @(posedge clk);
                drive_rx(8'h3C);
            end
        join
        repeat (4) @(posedge clk);
        #1 chk("dup_pulses", 32'(rdy_cnt - c0), 32'd1);
        chk("dup_resp", 32'(resp), 32'h3C);

        // 6. reset mid-frame
        send(16'h1111);
        repeat (3*B + 3) @(posedge clk);
        #1 chk("pre_rst_tx", 32'(TX), 32'd0);
        rst = 1'b1;
        #1 chk("mid_rst_tx", 32'(TX), 32'd1);
        chk("mid_rst_sent", 32'(cmd_sent), 32'd0);
        chk("mid_rst_rdy", 32'(resp_rdy), 32'd0);
        chk("mid_rst_resp", 32'(resp), 32'h00);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        send(16'h00FF);
        tx_cmd(16'h00FF, "c5");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
